// File: rtl/smem_text_writer_if.sv
// Command input and smem write bus of the screen-memory text writer.
interface smem_text_writer_if #(
    parameter int CW    = 2,
    parameter int Dbits = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_cmd;
    logic [CW-1:0]    in_char;
    logic             smem_wr;
    logic [Dbits-1:0] smem_addr;
    logic [CW-1:0]    smem_writedata;
    logic [5:0]       cursor_col;
    logic [4:0]       cursor_row;

    modport master (
        output in_valid, in_cmd, in_char,
        input  in_ready, smem_wr, smem_addr, smem_writedata, cursor_col, cursor_row
    );

    modport slave (
        input  in_valid, in_cmd, in_char,
        output in_ready, smem_wr, smem_addr, smem_writedata, cursor_col, cursor_row
    );
endinterface

// File: rtl/smem_text_writer.sv
// Text cursor and smem write front end: clears the 40x30 tile screen after
// reset or on request, then turns put-char/newline/backspace commands into
// single-cycle smem writes at 40*row + col.
module smem_text_writer #(
    parameter int numChars  = 4,
    parameter int Dbits     = 11,
    parameter int Cols      = 40,
    parameter int Rows      = 30,
    parameter int blankCode = 0
) (
    input logic           clk,
    input logic           reset,
    smem_text_writer_if.slave bus
);
    localparam int CW = $clog2(numChars);

    localparam logic [1:0]       CMD_PUT   = 2'b00;
    localparam logic [1:0]       CMD_NL    = 2'b01;
    localparam logic [1:0]       CMD_CLEAR = 2'b10;
    localparam logic [1:0]       CMD_BS    = 2'b11;
    localparam logic [5:0]       LAST_COL  = 6'(Cols - 1);
    localparam logic [4:0]       LAST_ROW  = 5'(Rows - 1);
    localparam logic [Dbits-1:0] LAST_ADDR = Dbits'(Cols * Rows - 1);
    localparam logic [CW-1:0]    BLANK     = CW'(blankCode);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t state_q, state_d;

    logic             wr_q, wr_d;
    logic [Dbits-1:0] addr_q, addr_d;
    logic [CW-1:0]    data_q, data_d;
    logic             ready_q, ready_d;
    logic [5:0]       col_q, col_d;
    logic [4:0]       row_q, row_d;
    logic [Dbits-1:0] sweep_q, sweep_d;

    logic       accept;
    logic [4:0] row_next;
    logic [5:0] bs_col;
    logic [4:0] bs_row;

    // 40*row + col built from shifts so no multiplier is inferred
    function automatic logic [Dbits-1:0] tile_addr(input logic [4:0] r, input logic [5:0] c);
        logic [Dbits-1:0] rr;
        rr = Dbits'(r);
        return (rr << 5) + (rr << 3) + Dbits'(c);
    endfunction

    // Handshake and cursor neighbours used by the command decode
    always_comb begin
        accept   = bus.in_valid & ready_q;
        row_next = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
        bs_col   = col_q;
        bs_row   = row_q;
        if (col_q != 6'd0) begin
            bs_col = col_q - 6'd1;
        end else if (row_q != 5'd0) begin
            bs_col = LAST_COL;
            bs_row = row_q - 5'd1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    // Next state: sweep ends after the last tile, clear command restarts it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (sweep_q == LAST_ADDR) state_d = S_IDLE;
            S_IDLE:  if (accept && bus.in_cmd == CMD_CLEAR) state_d = S_CLEAR;
            default: state_d = S_CLEAR;
        endcase
    end

    // Next values of the registered outputs, cursor and sweep counter
    always_comb begin
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_d = (state_q == S_IDLE);
        col_d   = col_q;
        row_d   = row_q;
        sweep_d = sweep_q;
        if (state_q == S_CLEAR) begin
            wr_d    = 1'b1;
            addr_d  = sweep_q;
            data_d  = BLANK;
            sweep_d = sweep_q + 1'b1;
            ready_d = 1'b0;
        end else if (accept) begin
            case (bus.in_cmd)
                CMD_PUT: begin
                    wr_d   = 1'b1;
                    addr_d = tile_addr(row_q, col_q);
                    data_d = bus.in_char;
                    if (col_q == LAST_COL) begin
                        col_d = 6'd0;
                        row_d = row_next;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
                CMD_NL: begin
                    col_d = 6'd0;
                    row_d = row_next;
                end
                CMD_CLEAR: begin
                    // first sweep write goes out immediately, the rest follow from S_CLEAR
                    wr_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = BLANK;
                    sweep_d = Dbits'(1);
                    col_d   = 6'd0;
                    row_d   = 5'd0;
                    ready_d = 1'b0;
                end
                CMD_BS: begin
                    wr_d   = 1'b1;
                    addr_d = tile_addr(bs_row, bs_col);
                    data_d = BLANK;
                    col_d  = bs_col;
                    row_d  = bs_row;
                end
                default: ;
            endcase
        end
    end

    // Output, cursor and sweep registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            col_q   <= 6'd0;
            row_q   <= 5'd0;
            sweep_q <= '0;
        end else begin
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sweep_q <= sweep_d;
        end
    end

    assign bus.in_ready       = ready_q;
    assign bus.smem_wr        = wr_q;
    assign bus.smem_addr      = addr_q;
    assign bus.smem_writedata = data_q;
    assign bus.cursor_col     = col_q;
    assign bus.cursor_row     = row_q;
endmodule

// File: tb/tb_smem_text_writer.sv
// Directed bench for smem_text_writer: sweeps, cursor motion, wraps, resets.
module tb_smem_text_writer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    smem_text_writer_if #(.CW(2), .Dbits(11)) bus ();

    smem_text_writer #(
        .numChars(4), .Dbits(11), .Cols(40), .Rows(30), .blankCode(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a command and let one clock edge pass (ends on a negedge)
    task automatic drive(input logic [1:0] cmd, input logic [1:0] ch);
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_char  = ch;
        @(negedge clk);
    endtask

    task automatic moves(input logic [1:0] cmd, input logic [1:0] ch, input int n);
        for (int i = 0; i < n; i++) drive(cmd, ch);
    endtask

    task automatic release_bus(input string tag);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_nowr"}, 32'(bus.smem_wr), 0);
    endtask

    // One accepted command followed by a check of the cycle that follows it
    task automatic step(input string tag, input logic [1:0] cmd, input logic [1:0] ch,
                        input bit exp_wr, input int exp_addr, input int exp_data,
                        input int exp_col, input int exp_row);
        drive(cmd, ch);
        check_eq({tag, "_wr"}, 32'(bus.smem_wr), 32'(exp_wr));
        if (exp_wr) begin
            check_eq({tag, "_addr"}, 32'(bus.smem_addr), exp_addr);
            check_eq({tag, "_data"}, 32'(bus.smem_writedata), exp_data);
        end
        check_eq({tag, "_col"}, 32'(bus.cursor_col), exp_col);
        check_eq({tag, "_row"}, 32'(bus.cursor_row), exp_row);
    endtask

    // Follow a blanking sweep; abort_at >= 0 asserts reset once that address is seen
    task automatic sweep_watch(input string tag, input int abort_at, input bit hold_put);
        int idx = 0, cyc = 0, first = -1, gaps = 0, bad_addr = 0, bad_data = 0;
        bit done = 0, aborted = 0;
        while (!done && !aborted && cyc < 1400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && hold_put) begin
                bus.in_cmd  = 2'b00;
                bus.in_char = 2'd3;
            end
            if (bus.in_ready) begin
                done = 1;
            end else if (bus.smem_wr) begin
                if (first < 0) first = cyc;
                if (int'(bus.smem_addr) != idx) bad_addr++;
                if (bus.smem_writedata != 2'd0) bad_data++;
                if (abort_at >= 0 && idx == abort_at) begin
                    reset   = 1'b1;
                    aborted = 1;
                end
                idx++;
            end else if (first >= 0) begin
                gaps++;
            end
        end
        check_eq({tag, "_first_lat"}, first, 1);
        check_eq({tag, "_addr_seq"}, bad_addr, 0);
        check_eq({tag, "_blank_data"}, bad_data, 0);
        check_eq({tag, "_gaps"}, gaps, 0);
        if (abort_at >= 0) begin
            check_eq({tag, "_writes_before_rst"}, idx, abort_at + 1);
        end else begin
            check_eq({tag, "_ready_rose"}, 32'(done), 1);
            check_eq({tag, "_writes"}, idx, 1200);
            check_eq({tag, "_ready_cycle"}, cyc, 1201);
            check_eq({tag, "_wr_at_ready"}, 32'(bus.smem_wr), 0);
            check_eq({tag, "_col"}, 32'(bus.cursor_col), 0);
            check_eq({tag, "_row"}, 32'(bus.cursor_row), 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_cmd   = 2'b00;
        bus.in_char  = 2'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_wr", 32'(bus.smem_wr), 0);
        check_eq("rst_addr", 32'(bus.smem_addr), 0);
        check_eq("rst_data", 32'(bus.smem_writedata), 0);
        check_eq("rst_ready", 32'(bus.in_ready), 0);
        check_eq("rst_col", 32'(bus.cursor_col), 0);
        check_eq("rst_row", 32'(bus.cursor_row), 0);
        reset = 1'b0;
        sweep_watch("boot_sweep", -1, 1'b0);

        // Three puts of code 2 back to back from (0,0)
        step("put0", 2'b00, 2'd2, 1, 0, 2, 1, 0);
        step("put1", 2'b00, 2'd2, 1, 1, 2, 2, 0);
        step("put2", 2'b00, 2'd2, 1, 2, 2, 3, 0);
        release_bus("put");

        // (3,0) -> (17,3), then newline
        moves(2'b01, 2'd0, 3);
        moves(2'b00, 2'd1, 17);
        step("nl_mid", 2'b01, 2'd0, 0, 0, 0, 0, 4);
        moves(2'b01, 2'd0, 25);
        step("nl_wrap", 2'b01, 2'd0, 0, 0, 0, 0, 0);

        // Backspace across a row boundary from (0,5)
        moves(2'b01, 2'd0, 5);
        step("bs_row", 2'b11, 2'd0, 1, 199, 0, 39, 4);
        release_bus("bs_row");

        // (39,4) -> (0,5) -> 25 newlines wrap to (0,0), backspace stays put
        moves(2'b00, 2'd1, 1);
        moves(2'b01, 2'd0, 25);
        step("bs_home", 2'b11, 2'd0, 1, 0, 0, 0, 0);
        moves(2'b00, 2'd1, 3);
        step("bs_mid", 2'b11, 2'd0, 1, 2, 0, 2, 0);

        // (2,0) -> (39,29), put wraps the cursor to (0,0)
        moves(2'b01, 2'd0, 29);
        moves(2'b00, 2'd2, 39);
        step("put_last", 2'b00, 2'd1, 1, 1199, 1, 0, 0);
        release_bus("put_last");

        // Clear mid-text, reset lands at sweep address 600, in_valid stays high
        step("put_pre", 2'b00, 2'd3, 1, 0, 3, 1, 0);
        bus.in_cmd = 2'b10;
        sweep_watch("clr_sweep", 600, 1'b1);
        @(negedge clk);
        check_eq("midrst_wr", 32'(bus.smem_wr), 0);
        check_eq("midrst_addr", 32'(bus.smem_addr), 0);
        check_eq("midrst_ready", 32'(bus.in_ready), 0);
        check_eq("midrst_col", 32'(bus.cursor_col), 0);
        reset = 1'b0;
        sweep_watch("restart_sweep", -1, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_sweep_wr", 32'(bus.smem_wr), 0);
        check_eq("post_sweep_col", 32'(bus.cursor_col), 0);
        check_eq("post_sweep_ready", 32'(bus.in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/smem_text_writer.md
# smem_text_writer

Write-side front end for the character-tile screen memory (smem) that the VGA display driver scans. Takes a stream of character and control commands from the CPU side through a valid/ready handshake, tracks a text cursor on the 40x30 tile grid, and issues single-cycle writes of character codes into smem at address 40*row + col. On reset, and on an explicit clear command, it sweeps the whole screen with a blank code before accepting further input.

## Interface
- numChars, 4, number of distinct tile bitmaps; character code width is CW = $clog2(numChars)
- Dbits, 11, smem address width (must hold Cols*Rows-1)
- Cols, 40, tile columns (640/16)
- Rows, 30, tile rows (480/16)
- blankCode, 0, character code written by clear and backspace

- clk  input  1  system clock, all logic rising-edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  block can accept a command this cycle
- in_cmd  input  2  00 = put char, 01 = newline, 10 = clear screen, 11 = backspace
- in_char  input  CW  character code, used only when in_cmd = 00
- smem_wr  output  1  smem write enable, one cycle per write
- smem_addr  output  Dbits  smem write address
- smem_writedata  output  CW  code to store
- cursor_col  output  6  current cursor column, 0..Cols-1
- cursor_row  output  5  current cursor row, 0..Rows-1

## Operation
- Two states:
  - CLEAR: sweeping smem.
  - IDLE: accepting commands.
- Reset forces CLEAR with the sweep counter at 0 and the cursor at (0,0). This holds on any cycle, including mid-sweep or mid-write; the sweep restarts from address 0.
- CLEAR:
  - Each cycle writes blankCode at the sweep counter, then increments the counter.
  - After the write to address Cols*Rows-1 (1199), the state goes to IDLE.
  - in_ready is 0 throughout; in_valid is ignored.
- IDLE: in_ready = 1. A command is accepted on any cycle with in_valid & in_ready.
- Put char:
  - Writes in_char at 40*row + col.
  - Then col+1. If col was Cols-1, col becomes 0 and row becomes row+1.
  - If row was Rows-1, row wraps to 0. No scrolling.
- Newline: no write. col becomes 0; row becomes row+1, with the same wrap as put char.
- Backspace:
  - Cursor moves back one cell: col-1. If col = 0, it goes to col = Cols-1 on row-1.
  - At (0,0) the cursor stays at (0,0).
  - Writes blankCode at the new cursor position.
- Clear:
  - Cursor goes to (0,0), the sweep counter to 0, and the state to CLEAR.
  - The full 1200-write sweep follows.
- Address arithmetic: 40*row is computed as (row<<5)+(row<<3), zero-extended to Dbits. No multiplier.
- Only one command is in flight at a time. Back-to-back accepted commands in IDLE produce back-to-back writes.

## Timing
- All outputs are registered.
- Reset values: smem_wr=0, smem_addr=0, smem_writedata=0, cursor_col=0, cursor_row=0, in_ready=0.
- Clear sweep timing:
  - The first sweep write (addr 0) is presented in the first cycle after reset deasserts.
  - It is followed by 1199 consecutive write cycles, with addresses strictly ascending by 1.
  - in_ready rises the cycle after addr 1199 is presented. Total busy time after reset is 1200 cycles.
- Put char and backspace: smem_wr/addr/data are presented the cycle after acceptance, for exactly one cycle. The cursor outputs update in that same cycle.
- Newline: the cursor updates the cycle after acceptance; smem_wr stays 0.
- Clear command: in_ready falls the cycle after acceptance, and the first sweep write appears in that same cycle.
- Sustained throughput in IDLE is one command per cycle.
- smem_wr is 0 in any cycle without a write.

## Test plan
- Reset, then idle:
  - Expect exactly 1200 smem_wr pulses, addr 0..1199, data 0.
  - in_ready=0 during the sweep and 1 afterwards; cursor (0,0).
- Put 'char 2' three times from (0,0):
  - Expect writes data=2 at addr 0,1,2 on consecutive cycles.
  - Cursor ends at (col 3, row 0).
- Cursor at (39,29), put char 1:
  - Expect a write at addr 1199.
  - Cursor wraps to (0,0).
- Cursor at (0,5), backspace:
  - Expect a blank write at addr 40*4+39 = 199.
  - Cursor becomes (39,4).
  - A further backspace from (0,0) writes addr 0 and the cursor stays at (0,0).
- Cursor at (17,3), newline:
  - No smem_wr; cursor becomes (0,4).
  - A newline at row 29 gives (0,0).
- Clear command mid-text, with reset asserted at sweep addr 600:
  - The sweep restarts at addr 0 and runs a full 1200 writes before in_ready=1.
  - in_valid held high during the sweep is not accepted.
